// File: rtl/fir_decimator.sv
// rtl/fir_decimator.sv - averaging decimator for the fir output sample stream
//
// Sums M = 1<<ratio accepted samples and emits their floor-average with a
// one-cycle valid strobe.
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   x        : signed W-bit input sample
//   en       : sample-accept strobe
//   ratio    : log2 of decimation ratio, latched at window start
//   y        : signed W-bit decimated sample, registered
//   y_valid  : one-cycle pulse after each completed window
module fir_decimator #(
   parameter int W        = 8,
   parameter int LOG2_MAX = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic signed [W-1:0] x,
   input  logic                en,
   input  logic [1:0]          ratio,
   output logic signed [W-1:0] y,
   output logic                y_valid
);

   localparam int AW = W + LOG2_MAX;

   logic signed [AW-1:0]   acc;
   logic [LOG2_MAX-1:0]    cnt;
   logic [1:0]             m_lat;

   logic                   win_start;
   logic [1:0]             eff_m;
   logic signed [AW-1:0]   x_ext;
   logic signed [AW-1:0]   sum;
   logic [LOG2_MAX:0]      cnt_inc;
   logic [LOG2_MAX:0]      win_len;
   logic                   win_last;

   // At window start the live ratio applies immediately so that M=1 windows
   // complete on the very sample that opens them.
   always_comb begin
      win_start = (cnt == '0);
      eff_m     = win_start ? ratio : m_lat;
      x_ext     = {{LOG2_MAX{x[W-1]}}, x};
      sum       = win_start ? x_ext : acc + x_ext;
      cnt_inc   = {1'b0, cnt} + (LOG2_MAX+1)'(1);
      win_len   = (LOG2_MAX+1)'(1) << eff_m;
      win_last  = (cnt_inc == win_len);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc     <= '0;
         cnt     <= '0;
         m_lat   <= '0;
         y       <= '0;
         y_valid <= 1'b0;
      end else begin
         y_valid <= en && win_last;
         if (en) begin
            acc   <= sum;
            m_lat <= eff_m;
            if (win_last) begin
               cnt <= '0;
               // Arithmetic shift floors toward -inf; the average always fits W bits.
               y   <= W'(sum >>> eff_m);
            end else begin
               cnt <= cnt_inc[LOG2_MAX-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_decimator.sv
// tb/tb_fir_decimator.sv - self-checking bench for fir_decimator
module tb_fir_decimator;

   logic              clk = 1'b0;
   logic              reset;
   logic signed [7:0] x;
   logic              en;
   logic [1:0]        ratio;
   logic signed [7:0] y;
   logic              y_valid;

   fir_decimator #(.W(8), .LOG2_MAX(3)) dut (
      .clk     (clk),
      .reset   (reset),
      .x       (x),
      .en      (en),
      .ratio   (ratio),
      .y       (y),
      .y_valid (y_valid)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // reference model state: samples of the open window and its ratio
   int win[$];
   int m_model = 1;
   int exp_y   = 0;
   int exp_v   = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int floor_avg(input int s, input int m);
      int q;
      q = s / m;
      if ((s % m) != 0 && s < 0) q = q - 1;
      return q;
   endfunction

   task automatic step(input int xv, input bit env, input int rv, input string tag);
      x     = 8'(xv);
      en    = env;
      ratio = 2'(rv);
      @(posedge clk);
      exp_v = 0;
      if (env) begin
         if (win.size() == 0) m_model = 1 << rv;
         win.push_back(xv);
         if (win.size() == m_model) begin
            int s;
            s = 0;
            foreach (win[i]) s += win[i];
            exp_y = floor_avg(s, m_model);
            exp_v = 1;
            win.delete();
         end
      end
      #1;
      chk({tag, ".v"}, int'(y_valid), exp_v);
      chk({tag, ".y"}, int'(y), exp_y);
   endtask

   task automatic do_reset(input string tag);
      en    = 1'b0;
      reset = 1'b1;
      #1;
      win.delete();
      exp_y = 0;
      exp_v = 0;
      chk({tag, ".async_v"}, int'(y_valid), 0);
      chk({tag, ".async_y"}, int'(y), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      en    = 1'b0;
      x     = '0;
      ratio = '0;
      #1;
      chk("reset.y", int'(y), 0);
      chk("reset.v", int'(y_valid), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // pass-through
      step(5, 1, 0, "pt0");
      step(-3, 1, 0, "pt1");
      step(127, 1, 0, "pt2");
      chk("pt_const", int'(y), 127);

      // average of four, back-to-back windows
      step(10, 1, 2, "a0"); step(20, 1, 2, "a1");
      step(30, 1, 2, "a2"); step(40, 1, 2, "a3");
      chk("avg4_const", int'(y), 25);
      step(0, 1, 2, "b0"); step(0, 1, 2, "b1");
      step(0, 1, 2, "b2"); step(4, 1, 2, "b3");
      chk("avg4b_const", int'(y), 1);

      // negative floor and extremes
      step(-1, 1, 1, "n0"); step(-2, 1, 1, "n1");
      chk("negfloor_const", int'(y), -2);
      for (int i = 0; i < 8; i++) step(127, 1, 3, "max");
      chk("max_const", int'(y), 127);
      for (int i = 0; i < 8; i++) step(-128, 1, 3, "min");
      chk("min_const", int'(y), -128);

      // gapped enable
      step(6, 1, 1, "g0");
      for (int i = 0; i < 3; i++) step(99, 0, 1, "gap");
      step(8, 1, 1, "g1");
      chk("gap_const", int'(y), 7);

      // ratio change mid-window
      step(4, 1, 2, "rc0"); step(4, 1, 2, "rc1");
      step(8, 1, 0, "rc2"); step(8, 1, 0, "rc3");
      chk("ratiochg_const", int'(y), 6);
      step(9, 1, 0, "rc4");
      chk("ratiochg_pt", int'(y), 9);

      // reset mid-window discards partial sum
      for (int i = 0; i < 5; i++) step(100, 1, 3, "rm");
      do_reset("rmid");
      for (int i = 0; i < 8; i++) step(16, 1, 3, "rf");
      chk("rstmid_const", int'(y), 16);

      // reset asserted in the completion cycle wins
      step(10, 1, 1, "cr0");
      x     = 8'(20);
      en    = 1'b1;
      ratio = 2'd1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      win.delete();
      exp_y = 0;
      exp_v = 0;
      chk("rstcomp.v", int'(y_valid), 0);
      chk("rstcomp.y", int'(y), 0);
      reset = 1'b0;

      // randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 59) == 0)
            do_reset("rnd_rst");
         else
            step(int'($urandom_range(0, 255)) - 128, ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)), "rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/fir_decimator.md
# fir_decimator

Averaging decimator that sits directly downstream of the `fir` filter and consumes its 8-bit output sample stream. It accumulates M consecutive accepted samples, M = 1, 2, 4 or 8 selected at run time, and emits their floor-average as one output sample with a single-cycle valid strobe. This reduces the output rate so slower consumers, such as pin-level serialisers or logic analysers, can follow the filtered signal.

## Interface
Parameters:
- `W`, default 8: sample width, two's-complement signed.
- `LOG2_MAX`, default 3: maximum log2 of the decimation ratio. Accumulator width is W+LOG2_MAX.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `x`  in  W: signed input sample from `fir` output `y`.
- `en`  in  1: sample-accept strobe. `x` is consumed on a rising edge where `en`=1. Tie high for one sample per cycle.
- `ratio`  in  2: log2 of the decimation ratio M (0→1, 1→2, 2→4, 3→8). Sampled only at window start.
- `y`  out  W: signed decimated sample, registered.
- `y_valid`  out  1: one-cycle pulse, high in the cycle after a window completes.

## Operation
Internal registers:
- `acc`: signed, W+LOG2_MAX bits.
- `cnt`: LOG2_MAX bits, count of accepted samples in the current window.
- `m_lat`: 2 bits, ratio latched for the current window.

Window start (`cnt`=0) with `en`=1:
- `m_lat` ← `ratio`.
- `acc` ← sign-extended `x`.
- `cnt` ← 1.
- If `ratio`=0, the window completes in this same cycle.

Mid-window (`cnt`>0) with `en`=1:
- `acc` ← `acc` + sext(`x`).
- `cnt` ← `cnt`+1.

Completion occurs on the accepted sample that is the M-th of the window, M = 1<<`m_lat`:
- `y` ← (sum including this sample) >>> `m_lat`. Use an arithmetic shift, so the result is the floor toward −∞.
- `y_valid` ← 1.
- `cnt` ← 0.
- The next accepted sample starts a new window with no bubble.

`en`=0:
- `acc`, `cnt` and `m_lat` hold.
- `y_valid` ← 0.

Other rules:
- A `ratio` change mid-window is ignored until the next window start.
- The accumulator cannot overflow: 8 × (−128..127) fits in W+3 bits. No saturation logic.
- The result always lies within the signed W-bit range, so truncation to W bits is exact.
- `y` holds its last value until the next completion.

## Timing
Reset values, applied asynchronously:
- `y`=0, `y_valid`=0.
- `acc`=0, `cnt`=0, `m_lat`=0.

Latency and throughput:
- `y`/`y_valid` update on the same edge that accepts the M-th sample, and are visible in the following cycle.
- Latency is 1 cycle from the last sample of the window.
- With `en` tied high, `y_valid` pulses every M cycles. With M=1 it stays high continuously, and `y` follows `x` delayed by 1 cycle.
- `y_valid` is never high for more than 1 cycle per window.

Reset behaviour:
- Reset mid-window discards the partial sum.
- After reset deassertion, the first accepted sample starts a fresh window.
- Reset asserted in the completion cycle wins: `y_valid` stays 0.

## Test plan
- **Pass-through:** `ratio`=0, `en`=1, x = 5, −3, 127. Required: `y` = 5, −3, 127 one cycle later each, with `y_valid` high every cycle.
- **Average of four:** `ratio`=2, x = 10, 20, 30, 40 back-to-back. Required: `y`=25 and a single `y_valid` pulse in the cycle after the 40 is accepted. The next window then starts immediately, so x = 0, 0, 0, 4 gives `y`=1.
- **Negative floor and extremes:**
  - `ratio`=1, x = −1, −2 → `y`=−2.
  - `ratio`=3 with eight samples of 127 → `y`=127.
  - `ratio`=3 with eight samples of −128 → `y`=−128.
- **Gapped enable:** `ratio`=1, x=6 with `en`=1, then 3 cycles with `en`=0 and x=99, then x=8 with `en`=1. Required: `y`=7, and `y_valid` pulses once only, after the second accepted sample.
- **Ratio change mid-window:** start `ratio`=2, feed 2 samples of 4, switch `ratio` to 0, feed 2 samples of 8. Required: `y`=6 after the 4th sample. The next sample is then passed through at M=1.
- **Reset mid-window:** `ratio`=3, feed 5 samples of 100, assert `reset` for 1 cycle. Required: `y`=0 and `y_valid`=0 immediately. Eight samples of 16 then give `y`=16 with no contribution from the discarded samples.
